varredura_matriz: RTL and testbench

Column-scan controller for the 5×7 LED matrix of the irrigation panel. It shares the matrix between two pattern generators: the irrigation-type pattern ("rega" page) and the water-level pattern ("nivel" page). It paces the column multiplex, inserts an anti-ghosting blank at every column change, and latches the selected generator's row data. It changes the active page only at frame boundaries, either from the selector switch or by automatic alternation.

---
 rtl/varredura_matriz.sv | 127 ++++++++++++
 tb/tb_varredura_matriz.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/varredura_matriz.sv
// varredura_matriz -- column-scan controller for the 5x7 LED matrix of the
// irrigation panel.
//
// The matrix is shared by two pattern generators: the irrigation-type page
// ("rega", pagina = 0) and the water-level page ("nivel", pagina = 1). Each
// column slot lasts DIV_COLUNA clocks. The first BLANK clocks of a slot are
// blanked so that the previous column cannot ghost. On the edge that ends the
// last blank cycle, the row data of the active page is latched. The active
// page only changes on the last cycle of a frame (column 4, last count), so a
// frame never mixes pages.
//
// Ports:
//   clock          system clock, rising edge
//   resetN         asynchronous active-low reset
//   chaveSeletora  manual page request (0 = rega, 1 = nivel)
//   modoAlternado  1 = automatic page alternation every QUADROS_ALTERNA frames
//   dadosRega      row bits of the rega generator for colunaIndice
//   dadosNivel     row bits of the nivel generator for colunaIndice
//   colunaIndice   column being scanned, 0..4
//   pagina         active page
//   colunas        one-hot column drive, zero while blanked
//   linhas         latched row drive, zero while blanked
//   fimQuadro      one-cycle pulse on the last cycle of each frame
//
// Every output comes from a register. The next value of each output is
// computed from the next counter values, so colunas and linhas switch in the
// same cycle.
module varredura_matriz #(
    parameter int DIV_COLUNA      = 1000,
    parameter int BLANK           = 4,
    parameter int QUADROS_ALTERNA = 50
) (
    input  logic       clock,
    input  logic       resetN,
    input  logic       chaveSeletora,
    input  logic       modoAlternado,
    input  logic [6:0] dadosRega,
    input  logic [6:0] dadosNivel,
    output logic [2:0] colunaIndice,
    output logic       pagina,
    output logic [4:0] colunas,
    output logic [6:0] linhas,
    output logic       fimQuadro
);

    localparam int CNT_W = (DIV_COLUNA > 1) ? $clog2(DIV_COLUNA) : 1;
    localparam int CQ_W  = (QUADROS_ALTERNA > 1) ? $clog2(QUADROS_ALTERNA) : 1;

    localparam logic [CNT_W-1:0] CNT_ULTIMO  = CNT_W'(DIV_COLUNA - 1);
    localparam logic [CNT_W-1:0] CNT_AMOSTRA = CNT_W'(BLANK - 1);
    localparam logic [CNT_W-1:0] CNT_DRIVE   = CNT_W'(BLANK);
    localparam logic [CQ_W-1:0]  CQ_ULTIMO   = CQ_W'(QUADROS_ALTERNA - 1);
    localparam logic [2:0]       COL_ULTIMA  = 3'd4;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntProx;
    logic [2:0]       colunaProx;
    logic [CQ_W-1:0]  contQuadros;
    logic [CQ_W-1:0]  contQuadrosProx;
    logic             paginaProx;
    logic [4:0]       colunasProx;
    logic [6:0]       linhasProx;
    logic             fimQuadroProx;
    logic             fimColuna;
    logic             fimFrame;

    always_comb begin
        fimColuna       = (cnt == CNT_ULTIMO);
        fimFrame        = fimColuna && (colunaIndice == COL_ULTIMA);

        cntProx         = fimColuna ? '0 : cnt + 1'b1;
        colunaProx      = colunaIndice;
        if (fimColuna) begin
            colunaProx = (colunaIndice == COL_ULTIMA) ? 3'd0 : colunaIndice + 3'd1;
        end

        // Column bit follows the counter value the slot will hold next cycle.
        colunasProx     = (cntProx >= CNT_DRIVE) ? (5'b00001 << colunaProx) : 5'b00000;

        // Rows are sampled once per slot and cleared when the slot ends, so
        // they line up with the column bit and ignore later input changes.
        linhasProx      = linhas;
        if (cnt == CNT_AMOSTRA) begin
            linhasProx = pagina ? dadosNivel : dadosRega;
        end else if (fimColuna) begin
            linhasProx = '0;
        end

        fimQuadroProx   = (cntProx == CNT_ULTIMO) && (colunaProx == COL_ULTIMA);

        // Page decisions use the mode and switch values at the frame boundary only.
        paginaProx      = pagina;
        contQuadrosProx = contQuadros;
        if (fimFrame) begin
            if (!modoAlternado) begin
                paginaProx      = chaveSeletora;
                contQuadrosProx = '0;
            end else if (contQuadros == CQ_ULTIMO) begin
                paginaProx      = ~pagina;
                contQuadrosProx = '0;
            end else begin
                contQuadrosProx = contQuadros + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            cnt          <= '0;
            colunaIndice <= 3'd0;
            contQuadros  <= '0;
            pagina       <= 1'b0;
            colunas      <= 5'b00000;
            linhas       <= 7'h00;
            fimQuadro    <= 1'b0;
        end else begin
            cnt          <= cntProx;
            colunaIndice <= colunaProx;
            contQuadros  <= contQuadrosProx;
            pagina       <= paginaProx;
            colunas      <= colunasProx;
            linhas       <= linhasProx;
            fimQuadro    <= fimQuadroProx;
        end
    end

endmodule

// File: tb/tb_varredura_matriz.sv
// tb_varredura_matriz -- self-checking bench for varredura_matriz with
// DIV_COLUNA = 8, BLANK = 2, QUADROS_ALTERNA = 3.
//
// The reference model tracks time in cycles since reset release (t). Column,
// count, frame boundary and column drive follow from t by plain arithmetic.
// The model keeps only the page, the frame count of the alternate mode and
// the row value sampled in the current slot.
// The observed outputs are packed as {colunaIndice, pagina, colunas, linhas, fimQuadro}.
module tb_varredura_matriz;

    localparam int DIV    = 8;
    localparam int BLK    = 2;
    localparam int QA     = 3;
    localparam int QUADRO = 5 * DIV;

    logic       clock;
    logic       resetN;
    logic       chaveSeletora;
    logic       modoAlternado;
    logic [6:0] dadosRega;
    logic [6:0] dadosNivel;
    logic [2:0] colunaIndice;
    logic       pagina;
    logic [4:0] colunas;
    logic [6:0] linhas;
    logic       fimQuadro;

    int         nChecks = 0;
    int         nPass   = 0;

    // Reference model state.
    int         t;
    logic       expPag;
    int         expCq;
    logic [6:0] expLin;

    logic [16:0] obs;
    assign obs = {colunaIndice, pagina, colunas, linhas, fimQuadro};

    varredura_matriz #(
        .DIV_COLUNA      (DIV),
        .BLANK           (BLK),
        .QUADROS_ALTERNA (QA)
    ) dut (
        .clock         (clock),
        .resetN        (resetN),
        .chaveSeletora (chaveSeletora),
        .modoAlternado (modoAlternado),
        .dadosRega     (dadosRega),
        .dadosNivel    (dadosNivel),
        .colunaIndice  (colunaIndice),
        .pagina        (pagina),
        .colunas       (colunas),
        .linhas        (linhas),
        .fimQuadro     (fimQuadro)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Expected output vector for cycle t.
    function automatic logic [16:0] exp_vec();
        int         c;
        int         col;
        logic [4:0] cl;
        c   = t % DIV;
        col = (t / DIV) % 5;
        cl  = (c >= BLK) ? 5'(1 << col) : 5'b00000;
        return {3'(col), expPag, cl, (c >= BLK) ? expLin : 7'h00, (t % QUADRO) == QUADRO - 1};
    endfunction

    // Advance the model across one rising edge using the present inputs.
    task automatic model_edge();
        int c;
        c = t % DIV;
        if (c == BLK - 1) expLin = expPag ? dadosNivel : dadosRega;
        else if (c == DIV - 1) expLin = 7'h00;
        if ((t % QUADRO) == QUADRO - 1) begin
            if (!modoAlternado) begin
                expPag = chaveSeletora;
                expCq  = 0;
            end else if (expCq == QA - 1) begin
                expPag = ~expPag;
                expCq  = 0;
            end else begin
                expCq = expCq + 1;
            end
        end
        t = t + 1;
    endtask

    // Finish the current cycle; returns 1 time unit after the next rising edge.
    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    // Hold reset for a few edges, release 1 unit after an edge: the DUT then sits in cycle 0.
    task automatic do_reset(input logic modo);
        resetN        = 1'b0;
        modoAlternado = modo;
        chaveSeletora = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        resetN = 1'b1;
        t      = 0;
        expPag = 1'b0;
        expCq  = 0;
        expLin = 7'h00;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        dadosRega     = 7'h55;
        dadosNivel    = 7'h2A;
        chaveSeletora = 1'b1;
        modoAlternado = 1'b0;
        resetN        = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            #1;
            nChecks++;
            if (obs !== 17'h0)
                $display("FAIL reset_hold cyc=%0d got %h expected %h", i, obs, 17'h0);
            else nPass++;
        end
    endtask

    task automatic test_scan();
        dadosRega  = 7'h55;
        dadosNivel = 7'h2A;
        do_reset(1'b0);
        while (t < 50) begin
            nChecks++;
            if (obs !== exp_vec())
                $display("FAIL scan t=%0d got %h expected %h", t, obs, exp_vec());
            else nPass++;
            if (t == 1 || t == 2 || t == 8 || t == 10) begin
                nChecks++;
                if (colunas !== ((t == 2) ? 5'b00001 : (t == 10) ? 5'b00010 : 5'b00000))
                    $display("FAIL scan_col t=%0d got %b", t, colunas);
                else nPass++;
            end
            if (t == 39) begin
                nChecks++;
                if (fimQuadro !== 1'b1) $display("FAIL scan_fim t=39 got %b expected 1", fimQuadro);
                else nPass++;
            end
            step();
        end
    endtask

    task automatic test_row_hold();
        dadosRega  = 7'h11;
        dadosNivel = 7'h00;
        do_reset(1'b0);
        while (t < 26) begin
            nChecks++;
            if (obs !== exp_vec())
                $display("FAIL row_hold t=%0d got %h expected %h", t, obs, exp_vec());
            else nPass++;
            if (t == 15 || t == 18) begin
                nChecks++;
                if (linhas !== ((t == 15) ? 7'h11 : 7'h22))
                    $display("FAIL row_hold_val t=%0d got %h", t, linhas);
                else nPass++;
            end
            if (t == 12) dadosRega = 7'h22;
            step();
        end
    endtask

    task automatic test_manual_switch();
        dadosRega  = 7'h0C;
        dadosNivel = 7'h7F;
        do_reset(1'b0);
        while (t < 48) begin
            nChecks++;
            if (obs !== exp_vec())
                $display("FAIL manual t=%0d got %h expected %h", t, obs, exp_vec());
            else nPass++;
            if (t == 39 || t == 40) begin
                nChecks++;
                if (pagina !== (t == 40)) $display("FAIL manual_pag t=%0d got %b", t, pagina);
                else nPass++;
            end
            if (t == 42) begin
                nChecks++;
                if (linhas !== 7'h7F) $display("FAIL manual_lin t=42 got %h expected 7f", linhas);
                else nPass++;
            end
            if (t == 10) chaveSeletora = 1'b1;
            step();
        end
    endtask

    task automatic test_alternate();
        do_reset(1'b1);
        while (t < 370) begin
            nChecks++;
            if (obs !== exp_vec())
                $display("FAIL alternate t=%0d got %h expected %h", t, obs, exp_vec());
            else nPass++;
            if (t == 119 || t == 120 || t == 239 || t == 240 || t == 359 || t == 360) begin
                nChecks++;
                if (pagina !== ((t == 120 || t == 239 || t == 360) ? 1'b1 : 1'b0))
                    $display("FAIL alternate_pag t=%0d got %b", t, pagina);
                else nPass++;
            end
            chaveSeletora = 1'($urandom_range(0, 1));
            dadosRega     = 7'($urandom);
            dadosNivel    = 7'($urandom);
            step();
        end
    endtask

    // Continues from test_alternate, where pagina = 1 during frame 9.
    task automatic test_reset_mid_frame();
        while (t < 389) begin
            nChecks++;
            if (obs !== exp_vec())
                $display("FAIL midreset_pre t=%0d got %h expected %h", t, obs, exp_vec());
            else nPass++;
            step();
        end
        nChecks++;
        if (pagina !== 1'b1 || colunaIndice !== 3'd3) $display("FAIL midreset_pos got pg=%b ci=%0d expected 1/3", pagina, colunaIndice);
        else nPass++;
        resetN = 1'b0;
        #1;
        nChecks++;
        if (obs !== 17'h0) $display("FAIL midreset_async got %h expected %h", obs, 17'h0);
        else nPass++;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            nChecks++;
            if (obs !== 17'h0) $display("FAIL midreset_hold cyc=%0d got %h expected %h", i, obs, 17'h0);
            else nPass++;
        end
        @(posedge clock);
        #1;
        resetN = 1'b1;
        t      = 0;
        expPag = 1'b0;
        expCq  = 0;
        expLin = 7'h00;
        modoAlternado = 1'b0;
        while (t < 24) begin
            nChecks++;
            if (obs !== exp_vec())
                $display("FAIL midreset_restart t=%0d got %h expected %h", t, obs, exp_vec());
            else nPass++;
            dadosRega = 7'($urandom);
            step();
        end
    endtask

    task automatic test_mode_exit();
        do_reset(1'b1);
        while (t < 330) begin
            nChecks++;
            if (obs !== exp_vec())
                $display("FAIL mode_exit t=%0d got %h expected %h", t, obs, exp_vec());
            else nPass++;
            if (t == 199 || t == 200) begin
                nChecks++;
                if (pagina !== (t == 199) || dut.contQuadros !== ((t == 199) ? 2'd1 : 2'd0))
                    $display("FAIL mode_exit_pag t=%0d got pg=%b cq=%0d", t, pagina, dut.contQuadros);
                else nPass++;
            end
            if (t == 319 || t == 320) begin
                nChecks++;
                if (pagina !== (t == 320)) $display("FAIL mode_reenter t=%0d got %b", t, pagina);
                else nPass++;
            end
            if (t == 170) begin
                modoAlternado = 1'b0;
                chaveSeletora = 1'b0;
            end
            if (t == 205) modoAlternado = 1'b1;
            dadosRega  = 7'($urandom);
            dadosNivel = 7'($urandom);
            step();
        end
    endtask

    task automatic test_random();
        do_reset(1'($urandom_range(0, 1)));
        while (t < 800) begin
            nChecks++;
            if (obs !== exp_vec())
                $display("FAIL random t=%0d got %h expected %h", t, obs, exp_vec());
            else nPass++;
            dadosRega  = 7'($urandom);
            dadosNivel = 7'($urandom);
            if ($urandom_range(0, 9) == 0) chaveSeletora = ~chaveSeletora;
            if ($urandom_range(0, 59) == 0) modoAlternado = ~modoAlternado;
            step();
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        resetN        = 1'b0;
        chaveSeletora = 1'b0;
        modoAlternado = 1'b0;
        dadosRega     = 7'h00;
        dadosNivel    = 7'h00;
        t             = 0;
        expPag        = 1'b0;
        expCq         = 0;
        expLin        = 7'h00;

        test_reset();
        test_scan();
        test_row_hold();
        test_manual_switch();
        test_alternate();
        test_reset_mid_frame();
        test_mode_exit();
        test_random();

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
